img_frame_loader: RTL

- Upstream stage of the atrous-conv engine. Accepts one 64x64 grayscale frame as an 8-bit pixel stream with valid/ready handshake.
- Converts each pixel to the 13-bit signed 9.4 fixed-point image-memory format and writes it to image RAM in raster order.
- Then hands the frame to the conv engine via its ready/busy pair, waits for completion, and reports done.
- Frames are strictly serialized: no new pixels are accepted while the conv engine owns the memory.

---
 rtl/img_frame_loader.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/img_frame_loader.sv
// img_frame_loader
//
// Upstream stage of the atrous-conv engine. It accepts one IMG_W x IMG_H grayscale frame as a
// valid/ready pixel stream. Each pixel is converted to the signed 9.4 image-memory format by
// zero-extension and left shift, then written to image RAM in raster order. Once the frame is
// resident, the block hands it to the conv engine with conv_ready and waits for conv_busy to
// rise and fall. It then pulses done. No pixels are accepted while the engine owns the memory.
//
// Ports:
//   clk, reset            single rising-edge clock, asynchronous active-high reset
//   s_valid/s_ready       pixel stream handshake; s_data is an unsigned pixel
//   s_last                marks the final pixel of a frame
//   iwen/iwaddr/iwdata    image RAM write port (one-cycle write latency, no stall)
//   conv_ready            frame resident, offered to the conv engine
//   conv_busy             conv engine busy
//   done                  one-cycle pulse when the conv engine finishes a frame
//   frame_err             sticky framing-error flag (cleared only by reset)
//   frame_cnt             completed-frame count, wraps at 256 (cleared only by reset)
module img_frame_loader #(
    parameter int unsigned IMG_W  = 64,
    parameter int unsigned IMG_H  = 64,
    parameter int unsigned ADDR_W = 12,
    parameter int unsigned PIX_W  = 8,
    parameter int unsigned FRAC   = 4,
    parameter int unsigned DATA_W = 1 + PIX_W + FRAC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [PIX_W-1:0]  s_data,
    input  logic              s_last,
    output logic              iwen,
    output logic [ADDR_W-1:0] iwaddr,
    output logic [DATA_W-1:0] iwdata,
    output logic              conv_ready,
    input  logic              conv_busy,
    output logic              done,
    output logic              frame_err,
    output logic [7:0]        frame_cnt
);

    localparam int unsigned        NPIX      = IMG_W * IMG_H;
    localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(NPIX - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StHand,
        StRun,
        StDone
    } state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                s_ready_d;
    logic                iwen_d;
    logic [ADDR_W-1:0]   iwaddr_d;
    logic [DATA_W-1:0]   iwdata_d;
    logic                conv_ready_d;
    logic                done_d;
    logic                frame_err_d;
    logic [7:0]          frame_cnt_d;
    logic                beat;

    assign beat = s_valid & s_ready;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        s_ready_d    = s_ready;
        iwen_d       = 1'b0;
        iwaddr_d     = iwaddr;
        iwdata_d     = iwdata;
        conv_ready_d = conv_ready;
        done_d       = 1'b0;
        frame_err_d  = frame_err;
        frame_cnt_d  = frame_cnt;

        unique case (state_q)
            StIdle: begin
                s_ready_d = 1'b1;
                state_d   = StLoad;
            end
            StLoad: begin
                // s_ready is held low for the first LOAD cycle after DONE and raised here,
                // so it returns the cycle after the done pulse.
                s_ready_d = 1'b1;
                if (beat) begin
                    iwen_d   = 1'b1;
                    iwaddr_d = cnt_q;
                    iwdata_d = {1'b0, s_data, {FRAC{1'b0}}};
                    if (cnt_q == LAST_ADDR) begin
                        // Full frame: hand off even if s_last is missing, but flag it.
                        cnt_d     = '0;
                        s_ready_d = 1'b0;
                        state_d   = StHand;
                        if (!s_last) begin
                            frame_err_d = 1'b1;
                        end
                    end else if (s_last) begin
                        // Early s_last: pixel is written, partial frame is abandoned.
                        frame_err_d = 1'b1;
                        cnt_d       = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            StHand: begin
                s_ready_d    = 1'b0;
                conv_ready_d = 1'b1;
                if (conv_busy) begin
                    conv_ready_d = 1'b0;
                    state_d      = StRun;
                end
            end
            StRun: begin
                if (!conv_busy) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                done_d      = 1'b1;
                frame_cnt_d = frame_cnt + 8'd1;
                state_d     = StLoad;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            s_ready    <= 1'b0;
            iwen       <= 1'b0;
            iwaddr     <= '0;
            iwdata     <= '0;
            conv_ready <= 1'b0;
            done       <= 1'b0;
            frame_err  <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            s_ready    <= s_ready_d;
            iwen       <= iwen_d;
            iwaddr     <= iwaddr_d;
            iwdata     <= iwdata_d;
            conv_ready <= conv_ready_d;
            done       <= done_d;
            frame_err  <= frame_err_d;
            frame_cnt  <= frame_cnt_d;
        end
    end

endmodule
